// File: rtl/miriscv_arb_pkg.sv
// miriscv_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_e  : arbiter FSM states (idle / waiting for a response)
//   arb_master_e : requester index (M0 = fetch, M1 = LSU)
//   ARB_TIMEOUT_RDATA : read data returned to the owner when a response
//                       times out (used only with MIRISCV_ARB_TIMEOUT_EN)
package miriscv_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_master_e;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/miriscv_rr_arbiter2.sv
// miriscv_rr_arbiter2
// Two-input round-robin selector with its own last-grant register.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (last_grant -> M0)
//   req0, req1   : request inputs
//   update_en    : commit the current selection as the new last grant
//   sel          : selected requester (valid only when sel_valid)
//   sel_valid    : at least one request present
module miriscv_rr_arbiter2
    import miriscv_arb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0,
    input  logic        req1,
    input  logic        update_en,
    output arb_master_e sel,
    output logic        sel_valid
);

    arb_master_e last_grant;

    // On a conflict the requester that did not win last time is chosen.
    // last_grant only moves on update_en, so a stalled conflict keeps
    // presenting the same winner.
    always_comb begin
        sel_valid = req0 | req1;
        sel       = ARB_M0;
        if (req0 && req1) begin
            sel = (last_grant == ARB_M0) ? ARB_M1 : ARB_M0;
        end else if (req1) begin
            sel = ARB_M1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= ARB_M0;
        end else if (update_en) begin
            last_grant <= sel;
        end
    end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// miriscv_mem_arbiter
// Shares one req/gnt/rvalid memory port between the fetch port (M0, read
// only) and the LSU port (M1). One transaction in flight, round-robin on
// conflict, response routed to the requester that issued it. A new request
// may issue in the same cycle the previous response returns.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   m0_*                    : fetch requester (req/addr in, gnt/rvalid/rdata out)
//   m1_*                    : LSU requester (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*                   : memory master side
//   arb_err_o               : one-cycle pulse on response timeout
// Optional build macro: MIRISCV_ARB_TIMEOUT_EN enables the response timeout
// (TIMEOUT_CYCLES); without it arb_err_o is tied 0 and WAIT never expires.
//
// state    | meaning
// ARB_IDLE | nothing outstanding
// ARB_WAIT | one request accepted, awaiting mem_rvalid_i
module miriscv_mem_arbiter
    import miriscv_arb_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              arb_err_o
);

    arb_state_e  state, state_d;
    arb_master_e owner, owner_d;
    arb_master_e sel;
    logic        sel_valid;
    logic        wait_resp;
    logic        timeout;
    logic        ready;
    logic        issue;
    logic        handshake;
    logic        resp;
    logic [XLEN-1:0] resp_rdata;

    // Everything is gated by rst_i so all outputs read 0 while in reset.
    assign wait_resp = !rst_i && (state == ARB_WAIT) && mem_rvalid_i;
    assign ready     = !rst_i && ((state == ARB_IDLE) || wait_resp);
    assign issue     = ready && sel_valid;
    assign handshake = issue && mem_gnt_i;

    miriscv_rr_arbiter2 u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req0      (m0_req_i && ready),
        .req1      (m1_req_i && ready),
        .update_en (handshake),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

`ifdef MIRISCV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_inc;

    // Fires in the cycle the count of silent WAIT cycles reaches
    // TIMEOUT_CYCLES; a real response in that same cycle wins.
    assign tmo_inc = tmo_cnt + 1'b1;
    assign timeout = !rst_i && (state == ARB_WAIT) && !mem_rvalid_i
                     && (tmo_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i || handshake) begin
            tmo_cnt <= '0;
        end else if ((state == ARB_WAIT) && !mem_rvalid_i) begin
            tmo_cnt <= tmo_inc;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign arb_err_o = timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
            owner <= ARB_M0;
        end else begin
            state <= state_d;
            owner <= owner_d;
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        if (handshake) begin
            state_d = ARB_WAIT;
            owner_d = sel;
        end else if (wait_resp || timeout) begin
            state_d = ARB_IDLE;
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (issue) begin
            mem_req_o = 1'b1;
            if (sel == ARB_M1) begin
                mem_we_o    = m1_we_i;
                mem_be_o    = m1_be_i;
                mem_addr_o  = m1_addr_i;
                mem_wdata_o = m1_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = m0_addr_i;
            end
        end
    end

    assign m0_gnt_o = issue && (sel == ARB_M0) && mem_gnt_i;
    assign m1_gnt_o = issue && (sel == ARB_M1) && mem_gnt_i;

    assign resp       = wait_resp || timeout;
    assign resp_rdata = timeout ? XLEN'(ARB_TIMEOUT_RDATA) : mem_rdata_i;

    assign m0_rvalid_o = resp && (owner == ARB_M0);
    assign m1_rvalid_o = resp && (owner == ARB_M1);
    assign m0_rdata_o  = m0_rvalid_o ? resp_rdata : '0;
    assign m1_rdata_o  = m1_rvalid_o ? resp_rdata : '0;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
module tb_miriscv_mem_arbiter;

    localparam int XLEN = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_req_i;
    logic [XLEN-1:0]   m0_addr_i;
    logic              m0_gnt_o, m0_rvalid_o;
    logic [XLEN-1:0]   m0_rdata_o;
    logic              m1_req_i, m1_we_i;
    logic [XLEN/8-1:0] m1_be_i;
    logic [XLEN-1:0]   m1_addr_i, m1_wdata_i;
    logic              m1_gnt_o, m1_rvalid_o;
    logic [XLEN-1:0]   m1_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_addr_o, mem_wdata_o;
    logic              mem_gnt_i, mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              arb_err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic            idx;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    miriscv_mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .arb_err_o(arb_err_o)
    );

    // Response scoreboard: every response seen must match the oldest expectation.
    always @(negedge clk_i) begin
        if (m0_rvalid_o || m1_rvalid_o) begin
            exp_t exp_r;
            logic            got_idx;
            logic [XLEN-1:0] got_data;
            logic [XLEN-1:0] other_data;
            tests_run++;
            got_idx    = m1_rvalid_o;
            got_data   = m1_rvalid_o ? m1_rdata_o : m0_rdata_o;
            other_data = m1_rvalid_o ? m0_rdata_o : m1_rdata_o;
            if (m0_rvalid_o && m1_rvalid_o) begin
                tests_failed++;
                $display("FAIL resp_both: m0_rvalid=1 m1_rvalid=1, required only one");
            end else if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL resp_unexpected: m%0d rvalid data=%h, required no response", got_idx, got_data);
            end else begin
                exp_r = sb_q.pop_front();
                if (got_idx !== exp_r.idx || got_data !== exp_r.data || other_data !== '0) begin
                    tests_failed++;
                    $display("FAIL resp_route: got m%0d data=%h other_rdata=%h, required m%0d data=%h other_rdata=0",
                             got_idx, got_data, other_data, exp_r.idx, exp_r.data);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m0_addr_i = '0;
        m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic apply_reset();
        next_cycle();
        idle_inputs();
        rst_i = 1;
        next_cycle();
        rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        m0_req_i = 1; m0_addr_i = 32'h10; m1_req_i = 1; m1_we_i = 1; m1_be_i = 4'hF;
        m1_addr_i = 32'h20; m1_wdata_i = 32'h1; mem_gnt_i = 1; mem_rvalid_i = 1;
        mem_rdata_i = 32'hCAFE;
        @(negedge clk_i);
        tests_run++;
        if ({m0_gnt_o, m1_gnt_o, mem_req_o, mem_we_o, m0_rvalid_o, m1_rvalid_o, arb_err_o} !== 7'b0 ||
            mem_be_o !== '0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: gnt=%b%b req=%b we=%b rv=%b%b err=%b be=%h addr=%h, required all 0",
                     m0_gnt_o, m1_gnt_o, mem_req_o, mem_we_o, m0_rvalid_o, m1_rvalid_o, arb_err_o, mem_be_o, mem_addr_o);
        end
        next_cycle();
        idle_inputs();
        rst_i = 0;
    endtask

    task automatic test_m0_read();
        next_cycle();
        m0_req_i = 1; m0_addr_i = 32'h100; mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m0_gnt_o !== 1 || m1_gnt_o !== 0 || mem_req_o !== 1 || mem_addr_o !== 32'h100 ||
            mem_we_o !== 0 || mem_be_o !== 4'hF) begin
            tests_failed++;
            $display("FAIL m0_issue: gnt=%b%b req=%b addr=%h we=%b be=%h, required gnt0=1 req=1 addr=100 we=0 be=f",
                     m0_gnt_o, m1_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o);
        end
        sb_q.push_back('{idx: 1'b0, data: 32'h13});
        next_cycle();
        idle_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'h13;
        @(negedge clk_i);
        tests_run++;
        if (m0_rvalid_o !== 1 || m1_rvalid_o !== 0) begin
            tests_failed++;
            $display("FAIL m0_resp: rvalid=%b%b, required m0=1 m1=0", m0_rvalid_o, m1_rvalid_o);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        m0_req_i = 1; m0_addr_i = 32'h300;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h200; m1_wdata_i = 32'hA5A5A5A5; m1_be_i = 4'hF;
        mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m1_gnt_o !== 1 || m0_gnt_o !== 0 || mem_we_o !== 1 || mem_addr_o !== 32'h200 ||
            mem_wdata_o !== 32'hA5A5A5A5 || mem_be_o !== 4'hF) begin
            tests_failed++;
            $display("FAIL conflict_first: gnt=%b%b we=%b addr=%h wdata=%h, required m1 gnt we=1 addr=200 wdata=a5a5a5a5",
                     m0_gnt_o, m1_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        sb_q.push_back('{idx: 1'b1, data: 32'h0});
        next_cycle();
        m1_req_i = 0; m1_we_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h0;
        @(negedge clk_i);
        tests_run++;
        if (m0_gnt_o !== 1 || m1_gnt_o !== 0 || mem_addr_o !== 32'h300 || mem_we_o !== 0) begin
            tests_failed++;
            $display("FAIL b2b_m0: gnt=%b%b addr=%h we=%b, required m0 gnt addr=300 we=0",
                     m0_gnt_o, m1_gnt_o, mem_addr_o, mem_we_o);
        end
        sb_q.push_back('{idx: 1'b0, data: 32'h55});
        next_cycle();
        m1_req_i = 1; m1_addr_i = 32'h204;
        mem_rdata_i = 32'h55;
        @(negedge clk_i);
        tests_run++;
        if (m1_gnt_o !== 1 || m0_gnt_o !== 0 || mem_addr_o !== 32'h204) begin
            tests_failed++;
            $display("FAIL conflict_rr: gnt=%b%b addr=%h, required m1 gnt addr=204", m0_gnt_o, m1_gnt_o, mem_addr_o);
        end
        sb_q.push_back('{idx: 1'b1, data: 32'h77});
        next_cycle();
        m0_req_i = 0; m1_req_i = 0; mem_gnt_i = 0;
        mem_rdata_i = 32'h77;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_stall();
        // last grant is M1 here, so the stalled conflict must present M0
        m0_req_i = 1; m0_addr_i = 32'h400;
        m1_req_i = 1; m1_addr_i = 32'h500;
        mem_gnt_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (m0_gnt_o !== 0 || m1_gnt_o !== 0 || mem_req_o !== 1 || mem_addr_o !== 32'h400) begin
                tests_failed++;
                $display("FAIL stall_%0d: gnt=%b%b req=%b addr=%h, required gnt=00 req=1 addr=400",
                         i, m0_gnt_o, m1_gnt_o, mem_req_o, mem_addr_o);
            end
            next_cycle();
        end
        mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m0_gnt_o !== 1 || m1_gnt_o !== 0) begin
            tests_failed++;
            $display("FAIL stall_release: gnt=%b%b, required m0 only", m0_gnt_o, m1_gnt_o);
        end
        sb_q.push_back('{idx: 1'b0, data: 32'h99});
        next_cycle();
        @(negedge clk_i);
        tests_run++;
        if (m0_gnt_o !== 0 || m1_gnt_o !== 0 || mem_req_o !== 0) begin
            tests_failed++;
            $display("FAIL stall_single: gnt=%b%b req=%b while waiting, required 0", m0_gnt_o, m1_gnt_o, mem_req_o);
        end
        next_cycle();
        m0_req_i = 0; m1_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h99;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_spurious();
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            tests_run++;
            if (m0_rvalid_o !== 0 || m1_rvalid_o !== 0) begin
                tests_failed++;
                $display("FAIL spurious_%0d: rvalid=%b%b, required 00", i, m0_rvalid_o, m1_rvalid_o);
            end
            next_cycle();
        end
        mem_rvalid_i = 0;
        m1_req_i = 1; m1_addr_i = 32'h600; mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m1_gnt_o !== 1 || mem_addr_o !== 32'h600) begin
            tests_failed++;
            $display("FAIL spurious_idle: m1_gnt=%b addr=%h, required 1 addr=600", m1_gnt_o, mem_addr_o);
        end
        sb_q.push_back('{idx: 1'b1, data: 32'h66});
        next_cycle();
        idle_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'h66;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        m0_req_i = 1; m0_addr_i = 32'h700; mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m0_gnt_o !== 1) begin
            tests_failed++;
            $display("FAIL rstwait_issue: m0_gnt=%b, required 1", m0_gnt_o);
        end
        next_cycle();
        idle_inputs();
        rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1111;
        @(negedge clk_i);
        tests_run++;
        if (m0_rvalid_o !== 0 || m1_rvalid_o !== 0) begin
            tests_failed++;
            $display("FAIL rstwait_during: rvalid=%b%b, required 00", m0_rvalid_o, m1_rvalid_o);
        end
        next_cycle();
        rst_i = 0; mem_rdata_i = 32'h1234;
        @(negedge clk_i);
        tests_run++;
        if (m0_rvalid_o !== 0 || m1_rvalid_o !== 0) begin
            tests_failed++;
            $display("FAIL rstwait_late: rvalid=%b%b, required 00", m0_rvalid_o, m1_rvalid_o);
        end
        next_cycle();
        mem_rvalid_i = 0;
        m0_req_i = 1; m0_addr_i = 32'h704; mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m0_gnt_o !== 1 || mem_addr_o !== 32'h704) begin
            tests_failed++;
            $display("FAIL rstwait_next: m0_gnt=%b addr=%h, required 1 addr=704", m0_gnt_o, mem_addr_o);
        end
        sb_q.push_back('{idx: 1'b0, data: 32'h42});
        next_cycle();
        idle_inputs();
        mem_rvalid_i = 1; mem_rdata_i = 32'h42;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_timeout();
        m1_req_i = 1; m1_addr_i = 32'h800; mem_gnt_i = 1;
        @(negedge clk_i);
        tests_run++;
        if (m1_gnt_o !== 1) begin
            tests_failed++;
            $display("FAIL tmo_issue: m1_gnt=%b, required 1", m1_gnt_o);
        end
`ifdef MIRISCV_ARB_TIMEOUT_EN
        sb_q.push_back('{idx: 1'b1, data: 32'hDEADBEEF});
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 5) begin
                mem_rvalid_i = 1; mem_rdata_i = 32'h5555;
            end
            @(negedge clk_i);
            tests_run++;
            if (arb_err_o !== (c == 4) || m1_rvalid_o !== (c == 4)) begin
                tests_failed++;
                $display("FAIL tmo_cycle_%0d: err=%b m1_rvalid=%b, required %b", c, arb_err_o, m1_rvalid_o, (c == 4));
            end
        end
`else
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            idle_inputs();
            @(negedge clk_i);
            tests_run++;
            if (arb_err_o !== 0 || m1_rvalid_o !== 0) begin
                tests_failed++;
                $display("FAIL wait_hold_%0d: err=%b m1_rvalid=%b, required 0 0", c, arb_err_o, m1_rvalid_o);
            end
        end
        sb_q.push_back('{idx: 1'b1, data: 32'h88});
        next_cycle();
        mem_rvalid_i = 1; mem_rdata_i = 32'h88;
`endif
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        test_reset();
        test_m0_read();
        test_back_to_back();
        test_stall();
        test_spurious();
        test_reset_in_wait();
        test_timeout();
        next_cycle();
        next_cycle();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
- Shares one data-memory port between two requesters: M0, the instruction-fetch read port, and M1, the LSU load/store port.
- Both requesters and the memory use the core req/rvalid memory protocol, with a grant added.
- Sits between the miriscv core ports and a single-port SRAM/bus slave.
- One transaction is in flight at a time. Arbitration is round-robin. The response is routed back to the requester that issued the transaction.

Parameters:
- XLEN, 32, data/address width (from miriscv_pkg).
- TIMEOUT_CYCLES, 64, maximum cycles to wait for mem_rvalid_i (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  fetch read request
- m0_addr_i  in  XLEN  fetch address
- m0_gnt_o  out  1  fetch request accepted this cycle
- m0_rvalid_o  out  1  fetch response valid
- m0_rdata_o  out  XLEN  fetch read data
- m1_req_i  in  1  LSU request
- m1_we_i  in  1  LSU write enable
- m1_be_i  in  XLEN/8  LSU byte enables
- m1_addr_i  in  XLEN  LSU address
- m1_wdata_i  in  XLEN  LSU write data
- m1_gnt_o  out  1  LSU request accepted
- m1_rvalid_o  out  1  LSU response valid
- m1_rdata_o  out  XLEN  LSU read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  XLEN/8  memory byte enables
- mem_addr_o  out  XLEN  memory address
- mem_wdata_o  out  XLEN  memory write data
- mem_gnt_i  in  1  memory accepts request
- mem_rvalid_i  in  1  memory response; asserted once per accepted request, writes included
- mem_rdata_i  in  XLEN  memory read data
- arb_err_o  out  1  timeout pulse (tied 0 when the optional feature is off)

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE, owner=M0, last_grant=M0.
  - All registered state cleared; timeout counter cleared.
  - During reset all outputs are 0; m*_rvalid_o=0 even if mem_rvalid_i=1.
- States:
  - IDLE: nothing outstanding.
  - WAIT: one request accepted; awaiting mem_rvalid_i.
- Issue window, ready = (state==IDLE) | (state==WAIT & mem_rvalid_i). Back-to-back issue is allowed in the cycle the previous response arrives.
- Selection, combinational, only when ready:
  - Only one requester asserts req: it is selected.
  - Both assert req: the one not equal to last_grant is selected.
- Memory drive when ready and a requester is selected:
  - mem_req_o=1; mem_* fields are muxed from the selected requester.
  - M0 is driven as we=0, be='1.
- Grant: m*_gnt_o = selected & mem_gnt_i. Zero-latency pass-through.
- On handshake (mem_req_o & mem_gnt_i): owner<=sel, last_grant<=sel, state<=WAIT.
- Not ready or no request: mem_req_o=0 and all mem_* fields driven 0.
- Response:
  - In WAIT with mem_rvalid_i=1: m[owner]_rvalid_o=1 combinationally, m[owner]_rdata_o=mem_rdata_i.
  - The non-owner's rvalid=0 and rdata=0.
  - The next state is WAIT if a new handshake happens the same cycle, otherwise IDLE.
- mem_rvalid_i in IDLE (spurious or late) is ignored: no m*_rvalid_o.
- Requesters must hold req and payload stable until gnt. Dropping req before gnt is legal and issues nothing.
- Simultaneous req from M0 and M1 with mem_gnt_i=0: the selection is held, because last_grant does not change until a handshake.
- Reset mid-WAIT: the transaction is abandoned and the state goes to IDLE. A response arriving after reset is dropped.

Optional Feature:
- MIRISCV_ARB_TIMEOUT_EN defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on each handshake and increments each cycle in WAIT without rvalid.
  - When it reaches TIMEOUT_CYCLES: m[owner]_rvalid_o=1 with rdata=32'hDEADBEEF, arb_err_o pulses 1 cycle, state<=IDLE. No new issue in that cycle.
  - A later stray mem_rvalid_i is ignored.
- Not defined: no counter, arb_err_o=0, WAIT lasts indefinitely.

Decomposition:
- Package miriscv_arb_pkg:
  - state enum (ARB_IDLE, ARB_WAIT).
  - master index typedef (ARB_M0/ARB_M1).
  - ARB_TIMEOUT_RDATA constant 32'hDEADBEEF.
- Sub-module miriscv_rr_arbiter2: two-input round-robin selection plus last_grant register, with update-enable input. Reusable for future shared resources.

Test Plan:
- M0 read only: m0_req=1, addr=0x100, gnt=1, rvalid the next cycle with rdata=0x13 -> m0_gnt=1 in cycle 0, m0_rvalid=1 with rdata=0x13 in cycle 1, m1_rvalid=0.
- Conflict after reset: both req, M1 write addr=0x200, wdata=0xA5A5A5A5, be=4'hF -> M1 granted first with mem_we=1; then M0 granted in the cycle mem_rvalid returns (back-to-back); the next conflict is granted to M1.
- Stall: mem_gnt_i=0 for 3 cycles with both req -> no gnt, selection stable, mem_addr constant; gnt on cycle 4 -> exactly one handshake.
- Spurious response: mem_rvalid_i=1 while IDLE -> m0/m1_rvalid stay 0; state stays IDLE.
- Reset in WAIT: assert rst_i one cycle, then mem_rvalid_i=1 -> no m*_rvalid_o; the next M0 request is granted normally.
- With MIRISCV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: M1 read with no rvalid -> 4 cycles after handshake m1_rvalid=1, rdata=0xDEADBEEF, arb_err_o=1 for one cycle.
